// File: rtl/axis_frame_len_fifo_if.sv
// axis_frame_len_fifo_if: frame-length input and AXI-Stream length output of the length FIFO
interface axis_frame_len_fifo_if #(
    parameter int LEN_WIDTH = 16
);
    logic [LEN_WIDTH-1:0] frame_len;
    logic                 frame_len_valid;
    logic [LEN_WIDTH-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    modport master (
        input  frame_len, frame_len_valid, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid
    );
    modport slave (
        output frame_len, frame_len_valid, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/axis_frame_len_fifo.sv
// axis_frame_len_fifo: queues completed-frame lengths for an AXI-Stream consumer, counting drops
module axis_frame_len_fifo #(
    parameter int LEN_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_frame_len_fifo_if.master bus,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_count,
    input  logic                 clear_stats
);
    logic [LEN_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [LEN_WIDTH-1:0] tdata_q, tdata_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 armed_q;
    logic                 empty, do_rd, try_wr, do_wr, drop;
    always_comb begin
        empty      = count_q == '0;
        do_rd      = !empty && bus.m_axis_tready;
        try_wr     = armed_q && bus.frame_len_valid;
        do_wr      = try_wr && (count_q != CW'(DEPTH) || do_rd);
        drop       = try_wr && !do_wr;
        rd_ptr_d   = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d    = count_q + CW'(do_wr) - CW'(do_rd);
        // Head register: the next head is either the following slot or, if it isn't stored yet, the incoming length
        tdata_d    = do_rd ? (count_q == CW'(1) ? bus.frame_len : mem[rd_ptr_d])
                           : (empty && do_wr ? bus.frame_len : tdata_q);
        overflow_d = clear_stats ? 1'b0 : overflow_q | drop;
        drop_d     = clear_stats ? '0 : (drop && drop_q != '1 ? drop_q + CNT_WIDTH'(1) : drop_q);
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= bus.frame_len;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tdata_q    <= tdata_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            armed_q    <= 1'b1;
        end
    end
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = !empty;
    assign count             = count_q;
    assign full              = count_q == CW'(DEPTH);
    assign overflow          = overflow_q;
    assign drop_count        = drop_q;
endmodule

// File: tb/tb_axis_frame_len_fifo.sv
// tb_axis_frame_len_fifo: scoreboard bench for the frame-length FIFO at DEPTH=4
module tb_axis_frame_len_fifo;
    localparam int LW = 16;
    localparam int D  = 4;
    localparam int CN = 16;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_stats = 1'b0;
    logic [2:0]    count;
    logic          full, overflow;
    logic [CN-1:0] drop_count;
    axis_frame_len_fifo_if #(.LEN_WIDTH(LW)) bus ();
    axis_frame_len_fifo #(.LEN_WIDTH(LW), .DEPTH(D), .CNT_WIDTH(CN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .count(count), .full(full),
        .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    int m_cnt = 0;
    int m_drop = 0;
    bit m_ov = 1'b0;
    bit m_armed = 1'b0;
    logic [LW-1:0] sb [$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    // Called at a falling edge; drives one cycle, checks state, then advances past the rising edge
    task automatic cycle(input bit v, input logic [LW-1:0] len, input bit rdy, input bit clr);
        bit rd, wr;
        bus.frame_len_valid = v;
        bus.frame_len       = len;
        bus.m_axis_tready   = rdy;
        clear_stats         = clr;
        #1;
        check("count", count, m_cnt);
        check("tvalid", bus.m_axis_tvalid, m_cnt != 0);
        check("full", full, m_cnt == D);
        check("drop_count", drop_count, m_drop);
        check("overflow", overflow, m_ov);
        rd = m_cnt != 0 && rdy;
        if (rd) check("tdata", bus.m_axis_tdata, sb.pop_front());
        wr = v && m_armed && (m_cnt < D || rd);
        if (wr) sb.push_back(len);
        if (v && m_armed && !wr) begin
            m_ov = 1'b1;
            if (m_drop != 16'hffff) m_drop++;
        end
        if (clr) begin
            m_ov   = 1'b0;
            m_drop = 0;
        end
        m_cnt   = m_cnt + int'(wr) - int'(rd);
        m_armed = 1'b1;
        @(negedge clk);
    endtask
    task automatic do_reset();
        bus.frame_len_valid = 1'b0;
        bus.m_axis_tready   = 1'b0;
        clear_stats         = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_drop", drop_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tdata", bus.m_axis_tdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_cnt   = 0;
        m_drop  = 0;
        m_ov    = 1'b0;
        m_armed = 1'b0;
    endtask
    initial begin
        bus.frame_len       = '0;
        bus.frame_len_valid = 1'b0;
        bus.m_axis_tready   = 1'b0;
        @(negedge clk);
        do_reset();
        cycle(1, 16'd99, 0, 0);
        cycle(1, 16'd3, 0, 0);
        cycle(1, 16'd5, 0, 0);
        cycle(1, 16'd7, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 16'(20 + i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 16'(30 + i), 0, 0);
        cycle(1, 16'd9, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 16'd0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 16'(40 + i), 0, 0);
        cycle(1, 16'd77, 0, 1);
        cycle(0, 16'd0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 16'd0, 1, 0);
        for (int i = 1; i <= 10; i++) cycle(1, 16'(i), 1, 0);
        cycle(0, 16'd0, 1, 0);
        cycle(0, 16'd0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 16'(50 + i), 0, 0);
        cycle(0, 16'd0, 1, 0);
        cycle(0, 16'd0, 0, 0);
        do_reset();
        cycle(1, 16'd99, 0, 0);
        cycle(1, 16'd11, 0, 0);
        cycle(0, 16'd0, 1, 0);
        cycle(0, 16'd0, 0, 0);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0);
        for (int i = 0; i < 5; i++) cycle(0, 16'd0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_frame_len_fifo.md
AXIS_FRAME_LEN_FIFO -- requirements
Module: axis_frame_len_fifo

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16; width of frame length values, matching the upstream frame length monitor.
REQ-002 SHALL have parameter DEPTH, default 16; number of queued length entries; power of two, at least 2.
REQ-003 SHALL have parameter CNT_WIDTH, default 16; width of the drop counter.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port frame_len, input, LEN_WIDTH bits; completed-frame length from the upstream monitor.
REQ-007 SHALL have port frame_len_valid, input, 1 bit; single-cycle qualifier for frame_len, with no backpressure path.
REQ-008 SHALL have port m_axis_tdata, output, LEN_WIDTH bits; head-of-queue length.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit; the queue is non-empty.
REQ-010 SHALL have port m_axis_tready, input, 1 bit; downstream accept.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits; number of entries held.
REQ-012 SHALL have port full, output, 1 bit; count equals DEPTH.
REQ-013 SHALL have port overflow, output, 1 bit; sticky flag, set when at least one length has been dropped.
REQ-014 SHALL have port drop_count, output, CNT_WIDTH bits; number of dropped lengths, saturating.
REQ-015 SHALL have port clear_stats, input, 1 bit; synchronous clear of overflow and drop_count.

Function
REQ-016 SHALL define a read as m_axis_tvalid and m_axis_tready high at the same rising edge; on a read, the head entry is removed.
REQ-017 SHALL define a write attempt as frame_len_valid high at a rising edge.
REQ-018 SHALL accept a write attempt when count is less than DEPTH, or when a read occurs in the same cycle (full plus simultaneous read and write is accepted).
REQ-019 SHALL drop a write attempt that is not accepted and leave the queue contents unchanged.
REQ-020 SHALL store entries as a circular buffer with read and write pointers that wrap modulo DEPTH; entries SHALL leave in arrival order.
REQ-021 SHALL update count each cycle as +1 on an accepted write only, -1 on a read only, and unchanged on both or neither.
REQ-022 SHALL derive m_axis_tvalid, full and count from registered state only, with no combinational path from any input.
REQ-023 SHALL provide no bypass: a length written at edge N appears on m_axis_tvalid/m_axis_tdata after edge N, even if the queue was empty.
REQ-024 SHALL hold m_axis_tdata stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-025 SHALL make m_axis_tdata equal to the oldest held entry whenever m_axis_tvalid is high; its value is don't-care when the queue is empty.
REQ-026 SHALL set overflow on a dropped write.
REQ-027 SHALL increment drop_count by 1 on a dropped write and hold it at all-ones once it reaches all-ones.
REQ-028 SHALL, on clear_stats, set overflow to 0 and drop_count to 0 at the next edge; clear_stats SHALL take precedence over a drop in the same cycle, so neither is set by that drop.
REQ-029 SHALL NOT let clear_stats affect queue contents, pointers or count.
REQ-030 SHALL ignore m_axis_tready when the queue is empty; no pointer movement occurs.

Reset
REQ-031 SHALL, while rst_n is low, immediately and asynchronously force: pointers to 0, count to 0, m_axis_tvalid to 0, full to 0, overflow to 0, drop_count to 0.
REQ-032 SHALL reset m_axis_tdata to 0; storage array contents need not be reset.
REQ-033 SHALL discard all queued entries when reset is asserted mid-operation.
REQ-034 SHALL ignore frame_len_valid at the first edge after rst_n deasserts, and behave normally from the second edge on.

Verification
Scenarios use DEPTH=4 and CNT_WIDTH=16.
REQ-035 SHALL cover in-order drain: write 3, 5, 7 on consecutive cycles with m_axis_tready=0, then raise tready -> count reaches 3; tdata sequence 3, 5, 7; m_axis_tvalid falls after the third read; count returns to 0.
REQ-036 SHALL cover overflow: 6 writes with tready=0 -> full=1 after the 4th write; drop_count=2; overflow=1; the 4 stored values drain in order.
REQ-037 SHALL cover full plus simultaneous read and write: with the queue full, write 9 while tready=1 -> write accepted; drop_count unchanged; count stays 4; 9 is last out.
REQ-038 SHALL cover wrap-around: 10 write/read pairs of values 1..10 with tready=1 -> all 10 values arrive in order; count never exceeds 1; drop_count=0.
REQ-039 SHALL cover clear with a simultaneous drop: with drop_count=2, assert clear_stats together with a dropped write -> drop_count=0; overflow=0; count unchanged.
REQ-040 SHALL cover reset mid-operation: with 3 entries held and drop_count=1, pulse rst_n low -> immediately m_axis_tvalid=0, count=0, drop_count=0; a later write of 11 emerges as the first output.
